// File: rtl/cdb_arbiter_pkg.sv
// Shared core types for the common data bus: tagged results, the broadcast bus,
// functional-unit tag constants and small sizing helpers.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_REQ = 5;
  localparam int TAG_W       = 6;
  localparam int DATA_W      = 32;

  typedef logic [TAG_W-1:0]  cdb_tag_t;
  typedef logic [DATA_W-1:0] cdb_data_t;

  typedef struct packed {
    cdb_tag_t  tag;
    cdb_data_t val;
  } tagged_data_t;

  typedef struct packed {
    logic      valid;
    cdb_tag_t  tag;
    cdb_data_t data;
  } cdb_bus_t;

  localparam cdb_tag_t FU_TAG_ALU0 = 6'h01;
  localparam cdb_tag_t FU_TAG_ALU1 = 6'h02;
  localparam cdb_tag_t FU_TAG_MUL  = 6'h04;
  localparam cdb_tag_t FU_TAG_LSU  = 6'h08;
  localparam cdb_tag_t FU_TAG_BR   = 6'h10;

  function automatic cdb_tag_t fu_tag(input int fu);
    case (fu)
      0:       return FU_TAG_ALU0;
      1:       return FU_TAG_ALU1;
      2:       return FU_TAG_MUL;
      3:       return FU_TAG_LSU;
      4:       return FU_TAG_BR;
      default: return '0;
    endcase
  endfunction

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-to-arbiter bundle: per-FU requests and payloads in, one-hot grant and
// the registered CDB broadcast out. master = FU side, slave = arbiter side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
);

  logic         [NUM_REQ-1:0] req_i;
  tagged_data_t [NUM_REQ-1:0] req_data_i;
  logic         [NUM_REQ-1:0] grant_o;
  cdb_bus_t                   cdb_o;

  modport master (
    output req_i,
    output req_data_i,
    input  grant_o,
    input  cdb_o
  );

  modport slave (
    input  req_i,
    input  req_data_i,
    output grant_o,
    output cdb_o
  );

endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Combinational round-robin pick: first set request at or above ptr_i, else the
// lowest set request (the wrapped part of the scan). Zero latency, no state.
module rr_priority_picker #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;
  logic [N-1:0] pick_src;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      upper_mask[i] = (i >= int'(ptr_i));
    end
    upper_req = req_i & upper_mask;
    pick_src  = (|upper_req) ? upper_req : req_i;
    // Two's-complement trick isolates the lowest set bit.
    gnt_o     = pick_src & (~pick_src + N'(1));
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-hot grant in the request cycle, broadcast registered one cycle later.
// Round-robin with aging override; losers simply hold their request until granted.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_CDB_REQ,
  parameter int MAX_WAIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(MAX_WAIT + 1);

  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  cdb_bus_t                      cdb_q, cdb_d;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] aged;
  logic [NUM_REQ-1:0] aged_gnt;
  logic [NUM_REQ-1:0] gnt;

  rr_priority_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // A requester that has already lost MAX_WAIT times preempts the rotation.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      aged[i] = bus.req_i[i] && (wait_cnt_q[i] == CNT_W'(MAX_WAIT));
    end
    aged_gnt = aged & (~aged + NUM_REQ'(1));
    if (rst || flush) begin
      gnt = '0;
    end else if (|aged) begin
      gnt = aged_gnt;
    end else begin
      gnt = rr_gnt;
    end
  end

  assign bus.grant_o = gnt;
  assign bus.cdb_o   = cdb_q;

  always_comb begin
    ptr_d       = ptr_q;
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ptr_d       = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
        cdb_d.valid = 1'b1;
        cdb_d.tag   = bus.req_data_i[i].tag;
        cdb_d.data  = bus.req_data_i[i].val;
      end
      if (flush || !bus.req_i[i] || gnt[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != CNT_W'(MAX_WAIT)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      wait_cnt_q <= '0;
      cdb_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wait_cnt_q <= wait_cnt_d;
      cdb_q      <= cdb_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: two instances (aging at 3 and at NUM_REQ-1) share one stimulus
// stream; a negedge monitor pops expected grants and broadcasts from queues.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = NUM_CDB_REQ;

  typedef struct packed {
    logic [N-1:0] g_a;
    logic [N-1:0] g_b;
  } gexp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic         [N-1:0] req;
  tagged_data_t [N-1:0] req_data;

  gexp_t    gq[$];
  cdb_bus_t cq_a[$];
  cdb_bus_t cq_b[$];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N)) bus_a ();
  cdb_arbiter_if #(.NUM_REQ(N)) bus_b ();

  assign bus_a.req_i      = req;
  assign bus_a.req_data_i = req_data;
  assign bus_b.req_i      = req;
  assign bus_b.req_data_i = req_data;

  cdb_arbiter #(.NUM_REQ(N), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_a)
  );

  cdb_arbiter #(.NUM_REQ(N), .MAX_WAIT(N - 1)) dut_rr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic cdb_bus_t exp_cdb(input logic [N-1:0] g, input logic [31:0] base);
    cdb_bus_t c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        c.valid = 1'b1;
        c.tag   = fu_tag(i);
        c.data  = base + 32'(i);
      end
    end
    return c;
  endfunction

  // FU i presents {fu_tag(i), base+i}; squash drops a broadcast that a reset will kill.
  task automatic drive(input logic r, input logic fl, input logic [N-1:0] rq, input logic [31:0] base,
                       input logic [N-1:0] ga, input logic [N-1:0] gb, input bit squash);
    rst   = r;
    flush = fl;
    req   = rq;
    for (int i = 0; i < N; i++) req_data[i] = '{tag: fu_tag(i), val: base + 32'(i)};
    gq.push_back('{g_a: ga, g_b: gb});
    if (!squash) begin
      if (ga != '0) cq_a.push_back(exp_cdb(ga, base));
      if (gb != '0) cq_b.push_back(exp_cdb(gb, base));
    end
  endtask

  task automatic cyc(input logic r, input logic fl, input logic [N-1:0] rq, input logic [31:0] base,
                     input logic [N-1:0] ga, input logic [N-1:0] gb, input bit squash);
    @(posedge clk);
    #1;
    drive(r, fl, rq, base, ga, gb, squash);
  endtask

  initial begin : monitor
    gexp_t ge;
    forever begin
      @(negedge clk);
      if (gq.size() > 0) begin
        ge = gq.pop_front();
        check("grant_a", 64'(bus_a.grant_o), 64'(ge.g_a));
        check("grant_b", 64'(bus_b.grant_o), 64'(ge.g_b));
      end
      if (bus_a.cdb_o.valid) begin
        if (cq_a.size() == 0) check("cdb_a_spurious", 64'(bus_a.cdb_o), 64'd0);
        else check("cdb_a", 64'(bus_a.cdb_o), 64'(cq_a.pop_front()));
      end
      if (bus_b.cdb_o.valid) begin
        if (cq_b.size() == 0) check("cdb_b_spurious", 64'(bus_b.cdb_o), 64'd0);
        else check("cdb_b", 64'(bus_b.cdb_o), 64'(cq_b.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst      = 1'b1;
    flush    = 1'b0;
    req      = '0;
    req_data = '0;
    @(posedge clk);
    #1;
    check("reset_cdb", 64'(bus_a.cdb_o), 64'd0);
    check("reset_ptr", 64'(dut.ptr_q), 64'd0);
    check("reset_wait", 64'(dut.wait_cnt_q), 64'd0);
    check("reset_grant", 64'(bus_a.grant_o), 64'd0);

    // Reset mid-broadcast with FU1/FU2 pending
    cyc(0, 0, 5'b00110, 32'h100, 5'b00010, 5'b00010, 1);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(bus_a.cdb_o.valid), 64'd1);
    check("pre_rst_ptr", 64'(dut.ptr_q), 64'd2);
    drive(1, 0, 5'b00110, 32'h100, 5'b00000, 5'b00000, 1);
    #1;
    check("rst_async_cdb_a", 64'(bus_a.cdb_o), 64'd0);
    check("rst_async_cdb_b", 64'(bus_b.cdb_o), 64'd0);
    check("rst_async_ptr", 64'(dut.ptr_q), 64'd0);
    cyc(1, 0, 5'b00110, 32'h100, 5'b00000, 5'b00000, 1);
    cyc(0, 0, 5'b00110, 32'h200, 5'b00010, 5'b00010, 0);

    // Idle, then FU1 alone for three cycles
    cyc(0, 0, 5'b00000, 32'h0, 5'b00000, 5'b00000, 0);
    check("post_rst_ptr", 64'(dut.ptr_q), 64'd2);
    cyc(0, 0, 5'b00000, 32'h0, 5'b00000, 5'b00000, 0);
    check("idle_valid", 64'(bus_a.cdb_o.valid), 64'd0);
    cyc(0, 0, 5'b00010, 32'h10, 5'b00010, 5'b00010, 0);
    cyc(0, 0, 5'b00010, 32'h21, 5'b00010, 5'b00010, 0);
    cyc(0, 0, 5'b00010, 32'h32, 5'b00010, 5'b00010, 0);

    // Wrap: move ptr to 4, then FU4 and FU0 compete
    cyc(0, 0, 5'b01000, 32'h300, 5'b01000, 5'b01000, 0);
    cyc(0, 0, 5'b10001, 32'h400, 5'b10000, 5'b10000, 0);
    check("wrap_ptr4", 64'(dut.ptr_q), 64'd4);
    cyc(0, 0, 5'b10001, 32'h500, 5'b00001, 5'b00001, 0);
    cyc(0, 0, 5'b00000, 32'h0, 5'b00000, 5'b00000, 0);
    check("wrap_ptr1", 64'(dut.ptr_q), 64'd1);

    // Flush squashes FU3, which wins the next cycle
    cyc(0, 1, 5'b01000, 32'h600, 5'b00000, 5'b00000, 0);
    cyc(0, 0, 5'b01000, 32'h700, 5'b01000, 5'b01000, 0);
    check("flush_valid", 64'(bus_a.cdb_o.valid), 64'd0);
    check("flush_ptr", 64'(dut.ptr_q), 64'd1);
    cyc(0, 0, 5'b10000, 32'h800, 5'b10000, 5'b10000, 0);

    // Full load from ptr=0: aging at 3 reorders, aging at 4 keeps pure rotation
    cyc(0, 0, 5'b11111, 32'h900, 5'b00001, 5'b00001, 0);
    cyc(0, 0, 5'b11111, 32'hA00, 5'b00010, 5'b00010, 0);
    cyc(0, 0, 5'b11111, 32'hB00, 5'b00100, 5'b00100, 0);
    cyc(0, 0, 5'b11111, 32'hC00, 5'b01000, 5'b01000, 0);
    cyc(0, 0, 5'b11111, 32'hD00, 5'b00001, 5'b10000, 0);
    cyc(0, 0, 5'b11111, 32'hE00, 5'b00010, 5'b00001, 0);
    cyc(0, 0, 5'b00000, 32'h0, 5'b00000, 5'b00000, 0);

    // Aging: FU2 waits behind FU3, FU4, FU0, then is forced past FU1
    cyc(1, 0, 5'b00000, 32'h0, 5'b00000, 5'b00000, 0);
    cyc(0, 0, 5'b00100, 32'hA0, 5'b00100, 5'b00100, 0);
    cyc(0, 0, 5'b01101, 32'hB0, 5'b01000, 5'b01000, 0);
    cyc(0, 0, 5'b10101, 32'hC0, 5'b10000, 5'b10000, 0);
    cyc(0, 0, 5'b00101, 32'hD0, 5'b00001, 5'b00001, 0);
    cyc(0, 0, 5'b00110, 32'hE0, 5'b00100, 5'b00010, 0);
    cyc(0, 0, 5'b00000, 32'h0, 5'b00000, 5'b00000, 0);
    check("aging_ptr_a", 64'(dut.ptr_q), 64'd3);
    check("aging_ptr_b", 64'(dut_rr.ptr_q), 64'd2);
    cyc(0, 0, 5'b00000, 32'h0, 5'b00000, 5'b00000, 0);

    @(negedge clk);
    #1;
    check("drain_grant_q", 64'(gq.size()), 64'd0);
    check("drain_cdb_a", 64'(cq_a.size()), 64'd0);
    check("drain_cdb_b", 64'(cq_b.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
